// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_sb #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_RD    = 4,
    parameter int NUM_WR    = 2,
    parameter int NUM_ALLOC = 2,
    parameter int ZERO_REG  = 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_RD-1:0][$clog2(NUM_REGS)-1:0]       ra,
    output logic [NUM_RD-1:0][DATA_W-1:0]                 rd,
    output logic [NUM_RD-1:0]                             rrdy,
    input  logic [NUM_WR-1:0][$clog2(NUM_REGS)-1:0]       wa,
    input  logic [NUM_WR-1:0]                             wvalid,
    input  logic [NUM_WR-1:0][DATA_W-1:0]                 wd,
    input  logic [NUM_ALLOC-1:0][$clog2(NUM_REGS)-1:0]    aa,
    input  logic [NUM_ALLOC-1:0]                          avalid,
    input  logic                                          flush,
    output logic [$clog2(NUM_REGS):0]                     busy_cnt
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [ADDR_W:0]     r_busy_cnt;

    logic [NUM_WR-1:0]    w_wr_ok;
    logic [NUM_ALLOC-1:0] w_al_ok;
    logic [NUM_REGS-1:0]  w_busy_next;
    logic [ADDR_W:0]      w_busy_cnt_next;

    // Accesses to a hardwired zero register are dropped before they reach any state.
    always_comb begin
        w_wr_ok = '0;
        w_al_ok = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            w_wr_ok[w] = wvalid[w] && ((ZERO_REG == 0) || (wa[w] != '0));
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            w_al_ok[a] = avalid[a] && ((ZERO_REG == 0) || (aa[a] != '0));
        end
    end

    // Allocs are applied after write clears so a new producer keeps the register busy.
    always_comb begin
        w_busy_next = r_busy;
        for (int w = 0; w < NUM_WR; w++) begin
            if (w_wr_ok[w]) begin
                w_busy_next[wa[w]] = 1'b0;
            end
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (w_al_ok[a]) begin
                w_busy_next[aa[a]] = 1'b1;
            end
        end
        if (flush) begin
            w_busy_next = '0;
        end
        if (ZERO_REG != 0) begin
            w_busy_next[0] = 1'b0;
        end
    end

    always_comb begin
        w_busy_cnt_next = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_busy_cnt_next = w_busy_cnt_next + (ADDR_W+1)'(w_busy_next[r]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_next;
            r_busy_cnt <= w_busy_cnt_next;
        end
    end

    // Later ports are assigned last, so the highest matching port index wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_wr_ok[w]) begin
                    r_regs[wa[w]] <= wd[w];
                end
            end
        end
    end

    always_comb begin
        rd   = '0;
        rrdy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd[i]   = r_regs[ra[i]];
            rrdy[i] = !r_busy[ra[i]];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_wr_ok[w] && (wa[w] == ra[i])) begin
                    rd[i]   = wd[w];
                    rrdy[i] = 1'b1;
                end
            end
`else
`endif
            if ((ZERO_REG != 0) && (ra[i] == '0)) begin
                rd[i]   = '0;
                rrdy[i] = 1'b1;
            end
        end
    end

    assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a spec-level model predicts each cycle's read
// outputs, and a negedge monitor compares them against the DUT.
module tb_regfile_sb;

    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 32;
    localparam int NUM_RD    = 4;
    localparam int NUM_WR    = 2;
    localparam int NUM_ALLOC = 2;
    localparam int ZERO_REG  = 1;
    localparam int ADDR_W    = $clog2(NUM_REGS);

    logic clk;
    logic reset;
    logic [NUM_RD-1:0][ADDR_W-1:0]    ra;
    logic [NUM_RD-1:0][DATA_W-1:0]    rd;
    logic [NUM_RD-1:0]                rrdy;
    logic [NUM_WR-1:0][ADDR_W-1:0]    wa;
    logic [NUM_WR-1:0]                wvalid;
    logic [NUM_WR-1:0][DATA_W-1:0]    wd;
    logic [NUM_ALLOC-1:0][ADDR_W-1:0] aa;
    logic [NUM_ALLOC-1:0]             avalid;
    logic                             flush;
    logic [ADDR_W:0]                  busy_cnt;

    regfile_sb #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD),
        .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rrdy(rrdy),
        .wa(wa), .wvalid(wvalid), .wd(wd), .aa(aa), .avalid(avalid),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    typedef struct {
        logic [NUM_RD-1:0][DATA_W-1:0] rd;
        logic [NUM_RD-1:0]             rrdy;
        logic [ADDR_W:0]               cnt;
        int                            cycle;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   cycleNo = 0;

    logic [DATA_W-1:0]   mRegs [NUM_REGS];
    logic [NUM_REGS-1:0] mBusy;
    logic [ADDR_W:0]     mCnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isZero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == 0);
    endfunction

    task automatic modelClear();
        for (int r = 0; r < NUM_REGS; r++) mRegs[r] = '0;
        mBusy = '0;
        mCnt  = '0;
    endtask

    // What a reader sees this cycle: stored state, optionally overlaid by live writes.
    function automatic exp_t predict();
        exp_t e;
        for (int i = 0; i < NUM_RD; i++) begin
            e.rd[i]   = mRegs[ra[i]];
            e.rrdy[i] = !mBusy[ra[i]];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wvalid[w] && wa[w] == ra[i] && !isZero(ra[i])) begin
                    e.rd[i]   = wd[w];
                    e.rrdy[i] = 1'b1;
                end
            end
`endif
            if (isZero(ra[i])) begin
                e.rd[i]   = '0;
                e.rrdy[i] = 1'b1;
            end
        end
        e.cnt   = mCnt;
        e.cycle = cycleNo;
        return e;
    endfunction

    task automatic modelEdge();
        for (int w = 0; w < NUM_WR; w++) begin
            if (wvalid[w] && !isZero(wa[w])) begin
                mRegs[wa[w]] = wd[w];
                mBusy[wa[w]] = 1'b0;
            end
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (avalid[a] && !isZero(aa[a])) mBusy[aa[a]] = 1'b1;
        end
        if (flush) mBusy = '0;
        mCnt = (ADDR_W+1)'($countones(mBusy));
    endtask

    task automatic idleInputs();
        ra = '0; wa = '0; wvalid = '0; wd = '0;
        aa = '0; avalid = '0; flush = 1'b0;
    endtask

    task automatic applyStimulus();
        expQ.push_back(predict());
        @(posedge clk);
        if (reset) modelEdge();
        cycleNo++;
        #1;
    endtask

    // Reset lands mid-cycle; the same-cycle expectation checks the immediate clear.
    task automatic midCycleReset();
        #2;
        reset = 1'b0;
        idleInputs();
        ra = {ADDR_W'(9), ADDR_W'(7), ADDR_W'(5), ADDR_W'(1)};
        modelClear();
        applyStimulus();
        applyStimulus();
        #2;
        reset = 1'b1;
        @(posedge clk);
        cycleNo++;
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        for (int i = 0; i < NUM_RD; i++) begin
            nChecks++;
            if (rd[i] !== e.rd[i]) begin
                nFails++;
                $display("[TB] FAIL rd[%0d] cycle %0d: got %h expected %h", i, e.cycle, rd[i], e.rd[i]);
            end
        end
        nChecks++;
        if (rrdy !== e.rrdy) begin
            nFails++;
            $display("[TB] FAIL rrdy cycle %0d: got %b expected %b", e.cycle, rrdy, e.rrdy);
        end
        nChecks++;
        if (busy_cnt !== e.cnt) begin
            nFails++;
            $display("[TB] FAIL busy_cnt cycle %0d: got %0d expected %0d", e.cycle, busy_cnt, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    initial begin
        reset = 1'b0;
        idleInputs();
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        for (int k = 0; k < NUM_REGS / NUM_RD; k++) begin
            for (int i = 0; i < NUM_RD; i++) ra[i] = ADDR_W'(k * NUM_RD + i);
            applyStimulus();
        end

        idleInputs();
        aa[0] = 5; avalid = 2'b01; ra[0] = 5;
        applyStimulus();
        idleInputs(); ra[0] = 5;
        applyStimulus();
        wa[0] = 5; wvalid = 2'b01; wd[0] = 32'hDEADBEEF;
        applyStimulus();
        idleInputs(); ra[0] = 5;
        applyStimulus();

        wa = {ADDR_W'(7), ADDR_W'(7)}; wvalid = 2'b11;
        wd = {32'h22222222, 32'h11111111}; ra[1] = 7;
        applyStimulus();
        idleInputs(); ra[1] = 7;
        applyStimulus();

        aa[1] = 9; avalid = 2'b10; wa[1] = 9; wvalid = 2'b10; wd[1] = 32'h5; ra[2] = 9;
        applyStimulus();
        idleInputs(); ra[2] = 9;
        applyStimulus();

        aa = {ADDR_W'(2), ADDR_W'(1)}; avalid = 2'b11;
        applyStimulus();
        aa = {ADDR_W'(4), ADDR_W'(3)};
        applyStimulus();
        idleInputs(); ra = {ADDR_W'(4), ADDR_W'(3), ADDR_W'(2), ADDR_W'(1)};
        applyStimulus();
        flush = 1'b1; aa[0] = 6; avalid = 2'b01;
        applyStimulus();
        idleInputs(); ra = {ADDR_W'(6), ADDR_W'(9), ADDR_W'(2), ADDR_W'(1)};
        applyStimulus();

        aa = {ADDR_W'(0), ADDR_W'(0)}; avalid = 2'b11;
        wa[0] = 0; wvalid = 2'b01; wd[0] = 32'hFFFFFFFF;
        applyStimulus();
        idleInputs();
        applyStimulus();

        aa = {ADDR_W'(12), ADDR_W'(11)}; avalid = 2'b11;
        wa[0] = 13; wvalid = 2'b01; wd[0] = 32'hCAFEF00D;
        applyStimulus();
        midCycleReset();

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_RD; i++) ra[i] = ADDR_W'($urandom_range(NUM_REGS - 1));
            for (int w = 0; w < NUM_WR; w++) begin
                wa[w] = ADDR_W'($urandom_range(NUM_REGS - 1));
                wd[w] = $urandom;
            end
            for (int a = 0; a < NUM_ALLOC; a++) aa[a] = ADDR_W'($urandom_range(NUM_REGS - 1));
            wvalid = NUM_WR'($urandom);
            avalid = NUM_ALLOC'($urandom);
            if (c % 7 == 3) wa[1] = wa[0];
            if (c % 5 == 1) ra[0] = wa[1];
            if (c % 11 == 4) aa[1] = wa[0];
            flush = ($urandom_range(15) == 0);
            applyStimulus();
            if (c == 200) midCycleReset();
        end
        idleInputs();

        for (int t = 0; t < 20 && expQ.size() > 0; t++) @(posedge clk);
        if (expQ.size() > 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
